// File: rtl/up_pkg.sv
// Shared constants and types for the up instruction-fetch path.
package up_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer: entry 0 is always the head, so the
// head fields leave the block straight from flops.
module fetch_fifo
  import up_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem     [DEPTH];
  fetch_entry_t  w_mem_nxt [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic          r_valid;
  logic          w_pop;

  assign w_pop       = i_pop && (r_count != '0);
  assign w_wr_idx    = r_count - CW'(w_pop);
  assign w_count_nxt = r_count + CW'(i_push) - CW'(w_pop);

  // A pop shifts everything down one slot; a push lands just above the survivors.
  always_comb begin
    w_mem_nxt = r_mem;
    if (w_pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        w_mem_nxt[i] = r_mem[i + 1];
      end
    end
    if (i_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_mem_nxt[i] = i_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_count <= '0;
      r_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_mem   <= w_mem_nxt;
    end
  end

  assign o_head  = r_mem[0];
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch between Memoria32 (synchronous read) and the up decode
// stage: sequential issue, credit-limited by the buffer, with redirect.
module fetch_unit
  import up_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              nrst,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned       CW      = $clog2(DEPTH + 1);
  localparam int unsigned       OW      = CW + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_issue;
  logic              w_room;
  logic [CW-1:0]     w_count;
  logic [OW-1:0]     w_occ;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  assign w_pop   = instr_valid & instr_ready;
  assign w_flush = redirect & (r_state != IDLE);
  assign w_push  = r_inflight & ~w_flush;

  // Occupancy after this edge; one more issue must still fit when it returns.
  assign w_occ  = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_room = (w_occ < OW'(DEPTH));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH, HOLD: begin
        if (w_flush) begin
          w_state_nxt = FETCH;
        end else if (w_room) begin
          w_issue     = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch pointer and the single outstanding read slot.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_pc          <= word_align(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_flush) begin
        r_pc <= word_align(redirect_pc);
      end else if (w_issue) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight_pc <= r_pc;
      end
    end
  end

  assign mem_raddr   = r_pc;
  assign w_push_data = '{pc: r_inflight_pc, instr: mem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_valid (instr_valid),
    .o_count (w_count)
  );

  assign instr_out = w_head.instr;
  assign pc_out    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: delivered stream checked against a
// program-order model (next expected pc, restarted on redirect/reset).
module tb_fetch_unit;
  import up_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int unsigned DEPTH_A = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] mem_raddr, mem_rdata, redirect_pc, instr_out, pc_out;
  logic        redirect = 1'b0, instr_valid, instr_ready = 1'b0;
  logic [31:0] w_mem_raddr, w_mem_rdata, w_instr_out, w_pc_out;
  logic        w_instr_valid;
  logic        w_redirect = 1'b0, w_instr_ready = 1'b1;
  logic [31:0] w_redirect_pc = 32'h0;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_pc;
  logic        idle_cycle;

  always #5 clk = ~clk;

  // Memoria32 stand-ins: word n holds n, one-cycle read latency.
  always @(posedge clk) begin
    mem_rdata   <= {2'b00, mem_raddr[31:2]};
    w_mem_rdata <= {2'b00, w_mem_raddr[31:2]};
  end

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH_A)) dut (
    .clk(clk), .nrst(nrst), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_out(instr_out),
    .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(4)) dut_w (
    .clk(clk), .nrst(nrst), .mem_raddr(w_mem_raddr), .mem_rdata(w_mem_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .instr_out(w_instr_out),
    .pc_out(w_pc_out), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, score any consumption, then check hold/redirect effects.
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic        held, flushed;
    logic [31:0] h_pc, h_ins;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk("fifo_bound", 32'((32'(dut.w_count) + 32'(dut.w_push) - 32'(dut.w_pop)) <= 32'(DEPTH_A)), 32'd1);
    flushed = rd && !idle_cycle;
    held    = instr_valid && !rdy && !flushed;
    h_pc    = pc_out;
    h_ins   = instr_out;
    if (instr_valid && rdy) begin
      chk("pc_out", pc_out, exp_pc);
      chk("instr_out", instr_out, exp_pc >> 2);
      exp_pc = exp_pc + 32'd4;
    end
    if (flushed) exp_pc = {rpc[31:2], 2'b00};
    @(posedge clk);
    #1;
    idle_cycle = 1'b0;
    if (flushed) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
    if (held) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_pc", pc_out, h_pc);
      chk("hold_instr", instr_out, h_ins);
    end
  endtask

  task automatic do_reset();
    nrst        = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_raddr", mem_raddr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_raddr_w", w_mem_raddr, WRAP_PC);
    nrst       = 1'b0;
    exp_pc     = 32'h0;
    idle_cycle = 1'b1;
  endtask

  // Full-throughput stream straight out of reset (release cycle is c=0).
  task automatic run_stream(input int n, input bit check_wrap);
    logic [31:0] wpc;
    for (int c = 0; c < n; c++) begin
      chk("raddr_seq", mem_raddr, (c <= 1) ? 32'h0 : 32'(4 * (c - 1)));
      chk("valid_seq", 32'(instr_valid), 32'(c >= 3));
      if (check_wrap) begin
        chk("w_valid_seq", 32'(w_instr_valid), 32'(c >= 3));
        if (c >= 3) begin
          wpc = WRAP_PC + 32'(4 * (c - 3));
          chk("w_pc_seq", w_pc_out, wpc);
          chk("w_instr_seq", w_instr_out, wpc >> 2);
        end
      end
      cycle(1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    exp_pc     = 32'h0;
    idle_cycle = 1'b1;

    // Streaming from reset, plus the wrap-around instance.
    do_reset();
    run_stream(20, 1'b1);

    // Decode stalled: buffer fills, fetch holds; redirect during IDLE is ignored.
    do_reset();
    cycle(1'b0, 1'b1, 32'h0000_0500);
    chk("idle_redirect_ignored", mem_raddr, 32'h0);
    for (int c = 1; c < 10; c++) cycle(1'b0, 1'b0, 32'h0);
    chk("stall_raddr", mem_raddr, 32'h8);
    chk("stall_state", 32'(dut.r_state), 32'(HOLD));
    chk("stall_count", 32'(dut.w_count), 32'(DEPTH_A));
    chk("stall_head_pc", pc_out, 32'h0);
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 32'h0);

    // Redirect while the buffer is full.
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 32'h0);
    chk("full_before_redirect", 32'(dut.w_count), 32'(DEPTH_A));
    cycle(1'b0, 1'b1, 32'h0000_0103);
    chk("redirect_raddr", mem_raddr, 32'h0000_0100);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redirect_first_valid", 32'(instr_valid), 32'd1);
    chk("redirect_first_pc", pc_out, 32'h0000_0100);
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 32'h0);

    // Random ready and redirects.
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom);
    end

    // Reset pulse mid-stream.
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 32'h0);
    chk("pre_reset_valid", 32'(instr_valid), 32'd1);
    nrst = 1'b1;
    #1;
    chk("async_rst_raddr", mem_raddr, 32'h0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_instr", instr_out, 32'h0);
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk);
    #1;
    nrst       = 1'b0;
    exp_pc     = 32'h0;
    idle_cycle = 1'b1;
    run_stream(9, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries (legal 2..8).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_raddr  output  32  word address to Memoria32 read port.
REQ-006 SHALL have port mem_rdata  input  32  Memoria32 read data, valid one cycle after mem_raddr (synchronous read).
REQ-007 SHALL have port redirect  input  1  branch/jump taken, restart fetch.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address when redirect=1.
REQ-009 SHALL have port instr_out  output  32  instruction word at buffer head.
REQ-010 SHALL have port pc_out  output  32  address of instr_out.
REQ-011 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port instr_ready  input  1  decode stage (up) accepts head this cycle.

Function
REQ-013 SHALL hold FSM states IDLE, FETCH, HOLD; IDLE entered only by reset.
REQ-014 SHALL move IDLE -> FETCH on first rising edge with nrst=0.
REQ-015 SHALL in FETCH issue one read per cycle: mem_raddr=pc, pc <= pc+4 at next edge.
REQ-016 SHALL issue only when count + inflight - pop < DEPTH (pop = instr_valid & instr_ready); otherwise state HOLD, pc and mem_raddr frozen.
REQ-017 SHALL move HOLD -> FETCH in the cycle the issue condition becomes true again.
REQ-018 SHALL push {issued pc, mem_rdata} into the buffer on the edge after the issuing cycle's return cycle, i.e. first instr_valid=1 two edges after first issue.
REQ-019 SHALL drive instr_valid = (count != 0); instr_out/pc_out from buffer head, stable while instr_valid & !instr_ready.
REQ-020 SHALL allow simultaneous push and pop; count unchanged, full throughput 1 instr/cycle with instr_ready held 1.
REQ-021 SHALL compute pc modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
REQ-022 SHALL force pc[1:0]=2'b00 on RESET_PC and redirect_pc loads.
REQ-023 SHALL on redirect=1 (any state except IDLE): empty buffer, discard in-flight return, pc <= {redirect_pc[31:2],2'b00}, state FETCH; instr_valid=0 the next cycle.
REQ-024 SHALL give redirect priority over push, pop and issue in the same cycle; a pop in that cycle is still counted as consumed by decode.
REQ-025 SHALL ignore redirect in IDLE.
REQ-026 SHALL never push when buffer full (guaranteed by REQ-016; assertion in bench).

Reset
REQ-027 SHALL on nrst=1, immediately: state IDLE, pc=RESET_PC, mem_raddr=RESET_PC, count=0, inflight=0, instr_valid=0, instr_out=0, pc_out=0.
REQ-028 SHALL on reset mid-operation drop all buffered and in-flight instructions; no issue while nrst=1.

Structure
REQ-029 SHALL place FSM state enum, WORD_BYTES=4 and the 32-bit address/data width constants in shared package up_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo (DEPTH entries of {pc,instr}, push/pop/flush, count output).
REQ-031 SHALL keep memory and decode outside; fetch_unit connects between Memoria32 and up.

Verification
REQ-032 Reset release, instr_ready=1, memory word[n]=n -> issue at 0,4,8,...; instr_valid=1 two edges after first issue; pc_out/instr_out = 0/0, 4/1, 8/2 one per cycle; stop at pc 64 matches prior bench.
REQ-033 instr_ready=0 for 10 cycles -> exactly DEPTH=2 entries buffered, HOLD entered, mem_raddr frozen at 8; release -> 0,4,8 delivered in order, no loss/duplicate.
REQ-034 redirect=1, redirect_pc=32'h0000_0103 while buffer full -> instr_valid=0 next cycle, next issue 32'h0000_0100, first delivered pc_out=32'h100.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> delivered pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 nrst pulsed mid-stream with instr_valid=1 -> all outputs at REQ-027 values within same cycle; restart from RESET_PC.
REQ-037 redirect and pop same cycle with instr_ready toggling randomly -> no stale instruction from before redirect ever seen on instr_out.
